arm_decode_stage: RTL and testbench
===================================

# arm_decode_stage

Registered, flow-controlled decode stage for the ARM-subset core: it accepts fetched instructions over a valid/ready handshake and decodes them into the core's control bundle. It evaluates the condition field against an internal NZCV flag register and buffers the results in a parametrised FIFO for the execute stage. It also squashes a configurable branch shadow after taken branches and supports pipeline flush. It sits between fetch and execute and replaces the purely combinational decode path.

## Interface
- DEPTH, 2, output FIFO entries; power of two, ≥2.
- SHADOW, 2, accepted instructions dropped after each taken branch; 0 disables squashing.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; empties FIFO, clears shadow counter
- in_valid / in_ready  in / out  1 / 1  fetch handshake; transfer when both high
- in_instr  in  32  instruction word
- flag_we  in  2  bit1 writes N,Z; bit0 writes C,V
- flag_in  in  4  {N,Z,C,V} from execute
- out_valid / out_ready  out / in  1 / 1  execute handshake
- out_instr  out  32  instruction of FIFO head
- out_regwrite, out_memwrite, out_memtoreg, out_alusrc, out_branch, out_condpass  out  1 each  head control bits
- out_immsrc  out  2; out_aluctl  out  3; out_flagw  out  2
- flags  out  4  current NZCV register

## Operation
- Decoding:
  - Op = instr[27:26].
  - F = instr[24:21].
  - S = instr[20].
- Op=00 (data processing):
  - RegWrite=1.
  - ALUSrc=instr[25].
  - ImmSrc=00.
  - aluctl by F:
    - 0000→000, 0001→001, 0010→010, 0011→010, 0100→011, 0101→100, 0110→101, 0111→110, 1000→111, 1001→111, 1010→010, 1011→011, 1100→000, 1101→001, 1110→001, 1111→001.
  - FlagW=11 if S=1 or F∈{1000..1011}, else 00.
  - F∈{1000..1011} forces RegWrite=0.
- Op=01 (load/store):
  - ALUSrc=1, ImmSrc=01, aluctl=011.
  - S=1 → RegWrite=1, MemtoReg=1.
  - S=0 → MemWrite=1.
- Op=10 (branch):
  - Branch=1, ImmSrc=10, aluctl=000.
  - RegWrite=0.
- Op=11: all control bits 0 (NOP).
- Condition check (instr[31:28]) uses effective flags. Effective flags = the flag register with the same-cycle flag_we/flag_in write bypassed in.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) passes; 1111 fails.
- Condition fail: entry still enqueued with condpass=0 and regwrite, memwrite, flagw, branch forced 0.
- Taken branch = accepted, not squashed, Op=10, condpass=1.
- Taken branch loads the shadow counter with SHADOW. Each later acceptance with counter>0 is consumed (in_ready high) but not enqueued, and the counter decrements.
- Squashed instructions are not condition-checked and never reload the counter.
- Flag register updates every cycle from flag_we/flag_in, independent of handshakes and flush.

## Timing
- Reset (async, reset_n=0):
  - FIFO empty, out_valid=0.
  - flags=0000, shadow counter=0.
  - in_ready=1 on release.
  - Head control outputs read 0 while empty.
- Latency: accepted instruction appears at the head no earlier than the next rising edge.
- in_ready = !full, registered occupancy. No pass-through when full, even if out_ready=1.
- Push and pop in the same cycle keep occupancy unchanged; pointers wrap modulo DEPTH.
- out_valid = !empty. Head stays stable while out_valid=1 and out_ready=0.
- flush has priority over push and pop:
  - The cycle after flush, out_valid=0 and counter=0.
  - An instruction presented during flush is dropped, though in_ready reflects the pre-flush state.
- reset_n asserted mid-transfer aborts it; no partial state remains.
- Flag bypass applies only to the cycle in which flag_we is high.

## Test plan
- Reset, push E0811002 with out_ready=1:
  - out_valid rises 1 cycle later.
  - regwrite=1, alusrc=0, aluctl=011, flagw=00, condpass=1.
- Push E3500000 (CMP #0):
  - aluctl=010, alusrc=1, flagw=11, regwrite=0.
  - Then flag_we=11, flag_in=0100 in the same cycle as push 0A000004 (BEQ): condpass=1, branch=1.
- SHADOW=2: push EA000004, E5901000, E5801000, E0811002 back-to-back.
  - Only EA000004 and E0811002 emerge.
  - All four handshakes complete.
- Hold out_ready=0 and push DEPTH+1 words:
  - in_ready falls after DEPTH acceptances.
  - One pop re-raises in_ready next cycle.
  - Order is preserved across pointer wrap.
- Flags=0000, push 0A000004:
  - Entry emerges with condpass=0, branch=0.
  - No squash of following E5901000, which emerges with regwrite=1, memtoreg=1, immsrc=01.
- Fill 2 entries, assert flush with in_valid=1:
  - Next cycle out_valid=0 and flags unchanged.
  - Then pull reset_n low mid-stream: out_valid=0 immediately, flags=0000.

Source files
------------

// File: rtl/arm_decode_stage.sv
// arm_decode_stage: registered decode with NZCV condition check,
// branch-shadow squashing and an output FIFO toward execute.
module arm_decode_stage #(
    parameter int DEPTH  = 2,
    parameter int SHADOW = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [1:0]  flag_we,
    input  logic [3:0]  flag_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_regwrite,
    output logic        out_memwrite,
    output logic        out_memtoreg,
    output logic        out_alusrc,
    output logic        out_branch,
    output logic        out_condpass,
    output logic [1:0]  out_immsrc,
    output logic [2:0]  out_aluctl,
    output logic [1:0]  out_flagw,
    output logic [3:0]  flags
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(SHADOW + 2);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic        regwrite;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        branch;
        logic        condpass;
        logic [1:0]  immsrc;
        logic [2:0]  aluctl;
        logic [1:0]  flagw;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         dec;
    entry_t         head;
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count;
    logic [CW-1:0]  shadow;
    logic [3:0]     eff;
    logic [1:0]     op;
    logic [3:0]     f;
    logic           s, cond_ok, cmp_op;
    logic [2:0]     alu_dp;
    logic           accept, squash, push, pop, taken;

    assign op     = in_instr[27:26];
    assign f      = in_instr[24:21];
    assign s      = in_instr[20];
    assign cmp_op = (f[3:2] == 2'b10);

    assign eff[3:2] = flag_we[1] ? flag_in[3:2] : flags[3:2];
    assign eff[1:0] = flag_we[0] ? flag_in[1:0] : flags[1:0];

    // condition field evaluated on bypassed flags
    always_comb begin
        cond_ok = 1'b0;
        case (in_instr[31:28])
            4'h0: cond_ok = eff[2];
            4'h1: cond_ok = !eff[2];
            4'h2: cond_ok = eff[1];
            4'h3: cond_ok = !eff[1];
            4'h4: cond_ok = eff[3];
            4'h5: cond_ok = !eff[3];
            4'h6: cond_ok = eff[0];
            4'h7: cond_ok = !eff[0];
            4'h8: cond_ok = eff[1] && !eff[2];
            4'h9: cond_ok = !eff[1] || eff[2];
            4'hA: cond_ok = (eff[3] == eff[0]);
            4'hB: cond_ok = (eff[3] != eff[0]);
            4'hC: cond_ok = !eff[2] && (eff[3] == eff[0]);
            4'hD: cond_ok = eff[2] || (eff[3] != eff[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // data-processing ALU control by function field
    always_comb begin
        alu_dp = 3'b000;
        case (f)
            4'h0, 4'hC:               alu_dp = 3'b000;
            4'h1, 4'hD, 4'hE, 4'hF:   alu_dp = 3'b001;
            4'h2, 4'h3, 4'hA:         alu_dp = 3'b010;
            4'h4, 4'hB:               alu_dp = 3'b011;
            4'h5:                     alu_dp = 3'b100;
            4'h6:                     alu_dp = 3'b101;
            4'h7:                     alu_dp = 3'b110;
            default:                  alu_dp = 3'b111;
        endcase
    end

    // main decoder; a failed condition kills all side effects
    always_comb begin
        dec          = '0;
        dec.instr    = in_instr;
        dec.condpass = cond_ok;
        case (op)
            2'b00: begin
                dec.regwrite = !cmp_op;
                dec.alusrc   = in_instr[25];
                dec.aluctl   = alu_dp;
                dec.flagw    = (s || cmp_op) ? 2'b11 : 2'b00;
            end
            2'b01: begin
                dec.alusrc   = 1'b1;
                dec.immsrc   = 2'b01;
                dec.aluctl   = 3'b011;
                dec.regwrite = s;
                dec.memtoreg = s;
                dec.memwrite = !s;
            end
            2'b10: begin
                dec.branch = 1'b1;
                dec.immsrc = 2'b10;
            end
            default: ;
        endcase
        if (!cond_ok) begin
            dec.regwrite = 1'b0;
            dec.memwrite = 1'b0;
            dec.flagw    = 2'b00;
            dec.branch   = 1'b0;
        end
    end

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready && !flush;
    assign squash    = accept && (shadow != '0);
    assign push      = accept && !squash;
    assign pop       = out_valid && out_ready && !flush;
    assign taken     = push && (op == 2'b10) && cond_ok;

    // FIFO pointers, occupancy and branch-shadow counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            shadow <= '0;
        end else if (flush) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            shadow <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            if (squash)     shadow <= shadow - CW'(1);
            else if (taken) shadow <= CW'(SHADOW);
        end
    end

    // NZCV register follows execute every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags <= 4'b0000;
        else          flags <= eff;
    end

    // FIFO storage; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end

    assign head         = out_valid ? mem[rptr] : '0;
    assign out_instr    = head.instr;
    assign out_regwrite = head.regwrite;
    assign out_memwrite = head.memwrite;
    assign out_memtoreg = head.memtoreg;
    assign out_alusrc   = head.alusrc;
    assign out_branch   = head.branch;
    assign out_condpass = head.condpass;
    assign out_immsrc   = head.immsrc;
    assign out_aluctl   = head.aluctl;
    assign out_flagw    = head.flagw;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Bench for arm_decode_stage: vector table through a scoreboard,
// plus backpressure, flush and mid-stream reset sequences.
module tb_arm_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [1:0]  flag_we = '0;
    logic [3:0]  flag_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_instr;
    logic        out_regwrite, out_memwrite, out_memtoreg;
    logic        out_alusrc, out_branch, out_condpass;
    logic [1:0]  out_immsrc, out_flagw;
    logic [2:0]  out_aluctl;
    logic [3:0]  flags;

    arm_decode_stage #(.DEPTH(2), .SHADOW(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flag_we(flag_we), .flag_in(flag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_regwrite(out_regwrite),
        .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg),
        .out_alusrc(out_alusrc), .out_branch(out_branch),
        .out_condpass(out_condpass), .out_immsrc(out_immsrc),
        .out_aluctl(out_aluctl), .out_flagw(out_flagw), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  bits;   // regwrite,memwrite,memtoreg,alusrc,branch,condpass
        logic [1:0]  imm;
        logic [2:0]  alu;
        logic [1:0]  fw;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  we;
        logic [3:0]  fin;
        logic        emerge;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t got;
    vec_t vt[21];
    int   checks = 0;
    int   errors = 0;
    int   acc = 0;

    assign got = {out_instr, out_regwrite, out_memwrite, out_memtoreg,
                  out_alusrc, out_branch, out_condpass,
                  out_immsrc, out_aluctl, out_flagw};

    function automatic exp_t mk(logic [31:0] i, logic [5:0] b,
                                logic [1:0] imm, logic [2:0] alu,
                                logic [1:0] fw);
        exp_t e;
        e = {i, b, imm, alu, fw};
        return e;
    endfunction

    function automatic vec_t mv(logic [31:0] i, logic [1:0] we,
                                logic [3:0] fin, logic em, exp_t e);
        vec_t v;
        v.instr = i; v.we = we; v.fin = fin; v.emerge = em; v.e = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // drive one word until accepted; expectation queued on acceptance
    task automatic send(vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        flag_we  = v.we;
        flag_in  = v.fin;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                if (v.emerge) sb.push_back(v.e);
                acc++;
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: instr %h not accepted", v.instr);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flag_we  = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left want 0", sb.size());
            sb.delete();
        end
    endtask

    // scoreboard compare at each completed output handshake
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h want none", got);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL pop_%h: got %h want %h", e.instr, got, e);
                end
            end
        end
    end

    initial begin
        exp_t none;
        none = '0;
        vt[0]  = mv(32'hE0811002, 2'b00, 4'h0, 1, mk(32'hE0811002, 6'b100001, 2'b00, 3'b011, 2'b00));
        vt[1]  = mv(32'hE3500000, 2'b00, 4'h0, 1, mk(32'hE3500000, 6'b000101, 2'b00, 3'b010, 2'b11));
        vt[2]  = mv(32'h0A000004, 2'b11, 4'h4, 1, mk(32'h0A000004, 6'b000011, 2'b10, 3'b000, 2'b00));
        vt[3]  = mv(32'hE5901000, 2'b00, 4'h0, 0, none);
        vt[4]  = mv(32'hE5801000, 2'b00, 4'h0, 0, none);
        vt[5]  = mv(32'hE0811002, 2'b00, 4'h0, 1, mk(32'hE0811002, 6'b100001, 2'b00, 3'b011, 2'b00));
        vt[6]  = mv(32'h10811002, 2'b00, 4'h0, 1, mk(32'h10811002, 6'b000000, 2'b00, 3'b011, 2'b00));
        vt[7]  = mv(32'h00811002, 2'b00, 4'h0, 1, mk(32'h00811002, 6'b100001, 2'b00, 3'b011, 2'b00));
        vt[8]  = mv(32'hE0911002, 2'b11, 4'h0, 1, mk(32'hE0911002, 6'b100001, 2'b00, 3'b011, 2'b11));
        vt[9]  = mv(32'h0A000004, 2'b00, 4'h0, 1, mk(32'h0A000004, 6'b000000, 2'b10, 3'b000, 2'b00));
        vt[10] = mv(32'hE5901000, 2'b00, 4'h0, 1, mk(32'hE5901000, 6'b101101, 2'b01, 3'b011, 2'b00));
        vt[11] = mv(32'hE5801000, 2'b00, 4'h0, 1, mk(32'hE5801000, 6'b010101, 2'b01, 3'b011, 2'b00));
        vt[12] = mv(32'hC0811002, 2'b11, 4'h9, 1, mk(32'hC0811002, 6'b100001, 2'b00, 3'b011, 2'b00));
        vt[13] = mv(32'hB0811002, 2'b00, 4'h0, 1, mk(32'hB0811002, 6'b000000, 2'b00, 3'b011, 2'b00));
        vt[14] = mv(32'hF0811002, 2'b00, 4'h0, 1, mk(32'hF0811002, 6'b000000, 2'b00, 3'b011, 2'b00));
        vt[15] = mv(32'hE1A01002, 2'b00, 4'h0, 1, mk(32'hE1A01002, 6'b100001, 2'b00, 3'b001, 2'b00));
        vt[16] = mv(32'hEC000000, 2'b00, 4'h0, 1, mk(32'hEC000000, 6'b000001, 2'b00, 3'b000, 2'b00));
        vt[17] = mv(32'hEA000004, 2'b00, 4'h0, 1, mk(32'hEA000004, 6'b000011, 2'b10, 3'b000, 2'b00));
        vt[18] = mv(32'hE5901000, 2'b00, 4'h0, 0, none);
        vt[19] = mv(32'hE5801000, 2'b00, 4'h0, 0, none);
        vt[20] = mv(32'hE0811002, 2'b00, 4'h0, 1, mk(32'hE0811002, 6'b100001, 2'b00, 3'b011, 2'b00));

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_head", 32'(got), 32'h0);

        // first-transfer latency
        out_ready = 1'b1;
        send(vt[0]);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        drain();

        // vector table, streaming with out_ready high
        acc = 0;
        for (int i = 1; i < 21; i++) send(vt[i]);
        chk("handshakes", 32'(acc), 32'd20);
        drain();
        chk("flags_after_table", 32'(flags), 32'h9);

        // backpressure, pointer wrap and order
        out_ready = 1'b0;
        send(vt[0]);
        send(vt[15]);
        in_valid = 1'b1;
        in_instr = 32'hE3500000;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("hold_head_0", out_instr, 32'hE0811002);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_in_ready_2", 32'(in_ready), 32'd0);
        chk("hold_head_1", out_instr, 32'hE0811002);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        sb.push_back(vt[1].e);
        @(negedge clk);
        chk("reraise_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // flush with a taken branch in the FIFO
        out_ready = 1'b0;
        send(mv(32'hE0811002, 2'b11, 4'hA, 1, vt[0].e));
        send(vt[17]);
        in_valid = 1'b1;
        in_instr = 32'hE0811002;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_flags", 32'(flags), 32'hA);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(vt[10]);
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(vt[0]);
        in_valid = 1'b1;
        in_instr = 32'hE3500000;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_flags", 32'(flags), 32'h0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(vt[1]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
